// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared FIFO geometry constants used by the controller, the RAM instance and the
// level above them.
package ram_fifo_ctrl_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 9;
    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

endpackage : ram_fifo_ctrl_pkg

// File: rtl/ram_fifo_ctrl.sv
// Sequences an external single-port-write / async-read RAM as a circular FIFO with a
// registered valid/ready output stage, occupancy reporting and a sticky drop flag.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    input  logic                  FLUSH,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  DROP,
    output logic [ADDR_WIDTH-1:0] RAM_WR_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DIN,
    output logic                  RAM_WR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1) << ADDR_WIDTH;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  drop_q, drop_d;

    logic [PTR_W-1:0]      ram_cnt;
    logic                  ram_full;
    logic                  ram_empty;
    logic                  wr_en;
    logic                  load;

    // Wrap-bit pointers: the difference is the RAM occupancy, including the full case.
    assign ram_cnt   = wr_ptr_q - rd_ptr_q;
    assign ram_full  = (ram_cnt == DEPTH);
    assign ram_empty = (ram_cnt == '0);

    assign IN_READY  = ~ram_full & ~FLUSH & ~RST;
    assign FULL      = ~IN_READY;
    assign wr_en     = IN_VALID & IN_READY;
    assign load      = ~ram_empty & (~out_valid_q | OUT_READY);

    assign RAM_WR_EN   = wr_en;
    assign RAM_WR_ADDR = wr_ptr_q[ADDR_WIDTH-1:0];
    assign RAM_DIN     = IN_DATA;
    assign RAM_RD_ADDR = rd_ptr_q[ADDR_WIDTH-1:0];

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign DROP      = drop_q;
    assign COUNT     = ram_cnt + PTR_W'(out_valid_q);
    assign EMPTY     = (COUNT == '0);

    // Next-state: flush overrides all data movement; RAM contents are left as is.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        drop_d      = drop_q;

        if (FLUSH) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            drop_d      = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (load) begin
                out_data_d  = RAM_DOUT;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            end else if (out_valid_q && OUT_READY) begin
                out_valid_d = 1'b0;
            end
            if (IN_VALID && ram_full) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
        end
    end

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a 512x8 async-read RAM modelled alongside.
module tb_ram_fifo_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          drop;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wr_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [DEPTH];

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(clk), .RST(rst),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .FLUSH(flush), .COUNT(count), .FULL(full), .EMPTY(empty), .DROP(drop),
        .RAM_WR_ADDR(ram_wr_addr), .RAM_DIN(ram_din), .RAM_WR_EN(ram_wr_en),
        .RAM_RD_ADDR(ram_rd_addr), .RAM_DOUT(ram_dout)
    );

    always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
    assign ram_dout = mem[ram_rd_addr];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    bit streaming = 1'b0;

    // Reference: words in RAM, output-register occupancy, drop flag, expected word order.
    int            ram_n  = 0;
    bit            ov_m   = 1'b0;
    bit            drop_m = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: advances at each rising edge from the bench's own stimulus only.
    initial forever begin
        @(posedge clk);
        if (rst || flush) begin
            ram_n  = 0;
            ov_m   = 1'b0;
            drop_m = 1'b0;
            exp_q.delete();
        end else begin
            bit push, ld, cons;
            push = in_valid && (ram_n < DEPTH);
            ld   = (ram_n > 0) && (!ov_m || out_ready);
            cons = ov_m && out_ready;
            if (in_valid && ram_n == DEPTH) drop_m = 1'b1;
            if (cons) void'(exp_q.pop_front());
            if (push) exp_q.push_back(in_data);
            ram_n = ram_n + int'(push) - int'(ld);
            ov_m  = ld ? 1'b1 : (cons ? 1'b0 : ov_m);
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            bit rdy_e;
            int cnt_e;
            rdy_e = (ram_n != DEPTH) && !flush && !rst;
            cnt_e = ram_n + int'(ov_m);
            chk("count", 32'(count), 32'(cnt_e));
            chk("out_valid", 32'(out_valid), 32'(ov_m));
            chk("empty", 32'(empty), 32'(cnt_e == 0));
            chk("in_ready", 32'(in_ready), 32'(rdy_e));
            chk("full", 32'(full), 32'(!rdy_e));
            chk("drop", 32'(drop), 32'(drop_m));
            chk("ram_wr_en", 32'(ram_wr_en), 32'(in_valid && rdy_e));
            if (ov_m) begin
                if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
                else chk("scoreboard_nonempty", 32'(exp_q.size()), 32'(1));
            end
            if (streaming) chk("stream_count_le2", 32'(count <= 2), 32'(1));
        end
    end

    task automatic drain_to(input int target);
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((ram_n + int'(ov_m)) > target && guard < 2000) begin
            cyc();
            guard++;
        end
        out_ready = 1'b0;
        chk("drain_done", 32'(guard < 2000), 32'(1));
    endtask

    initial begin
        // Reset with a word offered throughout.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_drop", 32'(drop), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        cyc();

        // Single-word latency.
        in_valid = 1'b1; in_data = 8'hA5;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("lat_out_valid", 32'(out_valid), 32'(1));
        chk("lat_out_data", 32'(out_data), 32'(8'hA5));
        chk("lat_count", 32'(count), 32'(1));
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("lat_taken_valid", 32'(out_valid), 32'(0));
        chk("lat_taken_empty", 32'(empty), 32'(1));

        // Fill to capacity, then offer one more.
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            cyc();
        end
        in_valid = 1'b0;
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_count", 32'(count), 32'(DEPTH + 1));
        in_valid = 1'b1; in_data = 8'h3C;
        cyc();
        in_valid = 1'b0;
        chk("fill_drop", 32'(drop), 32'(1));
        chk("fill_count_after_drop", 32'(count), 32'(DEPTH + 1));
        drain_to(0);
        cyc();

        // Continuous streaming across pointer wrap.
        streaming = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc(); cyc();
        streaming = 1'b0;
        out_ready = 1'b0;
        chk("stream_empty", 32'(empty), 32'(1));

        // Random backpressure on both sides.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        drain_to(0);

        // Flush mid-operation with COUNT=40, output valid and drop set.
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        drain_to(40);
        chk("pre_flush_count", 32'(count), 32'(40));
        chk("pre_flush_valid", 32'(out_valid), 32'(1));
        chk("pre_flush_drop", 32'(drop), 32'(1));
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 32'(count), 32'(0));
        chk("flush_valid", 32'(out_valid), 32'(0));
        chk("flush_drop", 32'(drop), 32'(0));
        in_valid = 1'b1; in_data = 8'h11;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("post_flush_first", 32'(out_data), 32'(8'h11));
        chk("post_flush_count", 32'(count), 32'(1));
        drain_to(0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_fifo_ctrl
